// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller.
// Sequences one shared combinational full-adder cell over WIDTH-bit operands,
// LSB first, one bit per clock. {cout,sum} = a + b + cin (unsigned).
//
// Parameters:
//   WIDTH  operand/sum width, 2..32 (default 8)
// Ports:
//   clk    system clock, rising edge
//   rst    synchronous active-high reset
//   start  request an addition; sampled only in IDLE
//   a, b   operands, captured on the accepting edge
//   cin    carry-in, captured on the accepting edge
//   busy   high while the serial add is running
//   done   one-cycle pulse, result valid
//   sum    result; held until the next accepted start
//   cout   final carry-out; held with sum
//   ovf    signed overflow, held with sum (only with SERIAL_ADD_OVF_EN)
//
// Optional feature macro: SERIAL_ADD_OVF_EN adds the ovf output.

module serial_add_fa (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_co;

  serial_add_fa u_fa (
    .x  (sh_a[0]),
    .y  (sh_b[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sh_a  <= '0;
      sh_b  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sh_a  <= a;
            sh_b  <= b;
            carry <= cin;
            cnt   <= '0;
            sum   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          // Sum bits enter at the MSB so after WIDTH shifts bit 0 sits at sum[0].
          sum   <= {fa_s, sum[WIDTH-1:1]};
          sh_a  <= sh_a >> 1;
          sh_b  <= sh_b >> 1;
          carry <= fa_co;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            cout  <= fa_co;
`ifdef SERIAL_ADD_OVF_EN
            // carry still holds the carry into the MSB on this edge
            ovf   <= carry ^ fa_co;
`endif
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8): directed cases with literal
// expectations plus randomized traffic, all compared against a behavioural model.

module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int done_cnt   = 0;
  bit check_en   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (check_en && done) done_cnt <= done_cnt + 1;

  // Behavioural model: phase 0 = waiting, 1..W = bit cycles, W+1 = result cycle.
  int           phase = 0;
  logic [W-1:0] exp_sum = '0;
  logic         exp_cout = 1'b0;
  logic         exp_ovf = 1'b0;
  logic [W:0]   pend_total = '0;
  logic         pend_ovf = 1'b0;

  function automatic logic [W:0] add_of(input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  function automatic logic ovf_of(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic c);
    logic [W:0] t;
    t = add_of(x, y, c);
    return (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      phase    <= 0;
      exp_sum  <= '0;
      exp_cout <= 1'b0;
      exp_ovf  <= 1'b0;
    end else if (phase == 0) begin
      if (start) begin
        phase      <= 1;
        pend_total <= add_of(a, b, cin);
        pend_ovf   <= ovf_of(a, b, cin);
      end
    end else if (phase == W) begin
      phase    <= W + 1;
      exp_sum  <= pend_total[W-1:0];
      exp_cout <= pend_total[W];
      exp_ovf  <= pend_ovf;
    end else if (phase == W + 1) begin
      phase <= 0;
    end else begin
      phase <= phase + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (check_en) begin
      check("busy", {31'd0, busy}, {31'd0, (phase >= 1 && phase <= W)});
      check("done", {31'd0, done}, {31'd0, (phase == W + 1)});
      if (phase == 0 || phase == W + 1) begin
        check("sum", {24'd0, sum}, {24'd0, exp_sum});
        check("cout", {31'd0, cout}, {31'd0, exp_cout});
`ifdef SERIAL_ADD_OVF_EN
        check("ovf", {31'd0, ovf}, {31'd0, exp_ovf});
`endif
      end
    end
  end

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL wait_done: no done pulse within 100 cycles");
    end
  endtask

  task automatic pulse_start(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic c);
    @(posedge clk); #2;
    a = xa; b = xb; cin = c; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [W-1:0] xa, input logic [W-1:0] xb,
                        input logic c, input logic [W-1:0] rs, input logic rc);
    bit ok;
    pulse_start(xa, xb, c);
    wait_done(ok);
    if (ok) begin
      check({name, "_sum"}, {24'd0, sum}, {24'd0, rs});
      check({name, "_cout"}, {31'd0, cout}, {31'd0, rc});
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #2;
  endtask

  initial begin
    bit ok;
    int d0;
    int t0;
    int t1;

    // Reset
    rst = 1'b1;
    idle_cycles(2);
    rst = 1'b0;
    check_en = 1'b1;
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sum", {24'd0, sum}, 32'h00);
    check("rst_cout", {31'd0, cout}, 32'd0);
    idle_cycles(6);
    check("rst_no_done", done_cnt, 0);

    // Basic add, busy for exactly W cycles
    pulse_start(8'h35, 8'h4A, 1'b0);
    t0 = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) t0++;
      if (done) break;
    end
    check("basic_busy_cycles", t0, W);
    check("basic_done", {31'd0, done}, 32'd1);
    check("basic_sum", {24'd0, sum}, 32'h7F);
    check("basic_cout", {31'd0, cout}, 32'd0);

    // Carry chain and signed overflow
    run_op("carry", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1);
`ifdef SERIAL_ADD_OVF_EN
    check("carry_ovf", {31'd0, ovf}, 32'd0);
`endif
    run_op("ovf", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);
`ifdef SERIAL_ADD_OVF_EN
    check("ovf_ovf", {31'd0, ovf}, 32'd1);
`endif

    // Ignored start during RUN
    idle_cycles(2);
    d0 = done_cnt;
    pulse_start(8'h10, 8'h20, 1'b0);
    idle_cycles(2);
    a = 8'hFF; start = 1'b1;
    idle_cycles(1);
    start = 1'b0;
    wait_done(ok);
    if (ok) check("ignored_sum", {24'd0, sum}, 32'h30);
    idle_cycles(15);
    check("ignored_one_done", done_cnt - d0, 1);

    // Back-to-back with start held high
    @(posedge clk); #2;
    a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
    wait_done(ok);
    t0 = cyc;
    if (ok) check("b2b_sum0", {24'd0, sum}, 32'h02);
    for (int k = 0; k < 2; k++) begin
      wait_done(ok);
      t1 = cyc;
      if (ok) begin
        check("b2b_period", t1 - t0, W + 2);
        check("b2b_sum", {24'd0, sum}, 32'h02);
      end
      t0 = t1;
    end
    @(posedge clk); #2;
    start = 1'b0;
    idle_cycles(14);

    // Abort mid-RUN
    d0 = done_cnt;
    pulse_start(8'h55, 8'h66, 1'b1);
    idle_cycles(3);
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_sum", {24'd0, sum}, 32'h00);
    check("abort_cout", {31'd0, cout}, 32'd0);
    idle_cycles(15);
    check("abort_no_done", done_cnt - d0, 0);
    run_op("after_abort", 8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1);

    // Randomized traffic, occasional reset
    for (int i = 0; i < 800; i++) begin
      @(posedge clk); #2;
      a     = W'($urandom);
      b     = W'($urandom);
      cin   = 1'($urandom);
      start = ($urandom_range(0, 3) != 0);
      rst   = ($urandom_range(0, 99) == 0);
    end
    @(posedge clk); #2;
    start = 1'b0;
    rst = 1'b0;
    idle_cycles(W + 4);

    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial adder controller: sequences one shared 1-bit full-adder cell over WIDTH-bit operands, LSB first, one bit per clock.
- Owns the operand shift registers, the carry flip-flop, the bit counter and the start/busy/done handshake.
- Serves as the low-area alternative to a WIDTH-bit ripple adder in arithmetic datapaths; the full-adder cell is instantiated internally and is purely combinational.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  reset, synchronous, active-high
- start  input  1  request a new addition; sampled only in IDLE
- a  input  WIDTH  operand A; captured on the accepting edge
- b  input  WIDTH  operand B; captured on the accepting edge
- cin  input  1  carry-in; captured on the accepting edge
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse; result valid
- sum  output  WIDTH  result; holds its value until the next accepted start
- cout  output  1  final carry-out; holds its value with sum

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, carry FF=0, counter=0, shift regs=0. Reset has priority over every other input.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN: on an edge with start=1.
  - Load shift regs with a and b.
  - Load carry FF with cin.
  - Clear counter and the sum register.
- RUN, every edge:
  - Full-adder inputs: shA[0], shB[0], carry FF.
  - Shift adder sum into sum register from the MSB (sum <= {fa_s, sum[WIDTH-1:1]}).
  - Shift shA and shB right by 1; carry FF <= fa_cout; counter++.
- RUN -> DONE: on the edge where counter == WIDTH-1, i.e. after the WIDTH-th bit is processed. On that edge cout <= fa_cout.
- DONE: done=1 and busy=0 for exactly one cycle. The next edge returns to IDLE unconditionally.
- Latency: start sampled at edge k -> busy high in cycles k+1..k+WIDTH -> done high in the cycle after edge k+WIDTH. Total: WIDTH+1 cycles from acceptance to done.
- Arithmetic: {cout,sum} = a + b + cin, unsigned, modulo 2^(WIDTH+1); no saturation.
- start while RUN or DONE: ignored, no queuing. Operand changes after acceptance have no effect.
- start held high continuously: back-to-back operations, one every WIDTH+2 cycles (IDLE is visited for one cycle each time).
- sum and cout are intermediate during RUN. They are valid only from done onward and stay stable through IDLE until the next acceptance.
- Reset asserted mid-RUN: operation aborted, done is never pulsed, all outputs are zero on the next cycle.

Optional Feature:
- Macro: SERIAL_ADD_OVF_EN.
- Defined:
  - Extra output port ovf (1 bit, reset 0), updated together with cout.
  - ovf = two's-complement signed overflow = carry into MSB XOR carry out of MSB.
  - Captured from the carry FF value and fa_cout on the final RUN edge.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset: rst=1 for 2 cycles, then release -> busy=0, done=0, sum=8'h00, cout=0. No done pulse appears without start.
- Basic add, WIDTH=8: a=8'h35, b=8'h4A, cin=0, start pulsed -> busy high 8 cycles, then done pulses once with sum=8'h7F, cout=0.
- Carry chain: a=8'hFF, b=8'h00, cin=1 -> sum=8'h00, cout=1. With SERIAL_ADD_OVF_EN: ovf=0. Second run a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, cout=0, ovf=1.
- Ignored start: a=8'h10, b=8'h20, start again in RUN with a=8'hFF -> result sum=8'h30. The second start is dropped and only one done pulse occurs.
- Back-to-back: start held high with a=8'h01, b=8'h01 -> done pulses every 10 cycles, sum=8'h02 each time. sum stays stable between the done pulse and the next acceptance.
- Abort: rst asserted 4 cycles into RUN -> next cycle all outputs are 0, no done pulse. A subsequent start with a=8'hC8, b=8'h64 -> sum=8'h2C, cout=1.
